// File: rtl/tdc_sequencer_if.sv
// rtl/tdc_sequencer_if.sv - command, TDC and UART-transmit signals of the measurement sequencer
interface tdc_sequencer_if #(
  parameter int POS_W = 4
);
  logic             cmd_valid;
  logic [7:0]       cmd_data;
  logic [POS_W-1:0] pos_i;
  logic             tdc_launch;
  logic             tx_start;
  logic [7:0]       tx_data;
  logic             tx_busy;
  logic             busy;
  logic             cmd_drop;

  modport master (
    output cmd_valid, cmd_data, pos_i, tx_busy,
    input  tdc_launch, tx_start, tx_data, busy, cmd_drop
  );

  modport slave (
    input  cmd_valid, cmd_data, pos_i, tx_busy,
    output tdc_launch, tx_start, tx_data, busy, cmd_drop
  );
endinterface

// File: rtl/tdc_sequencer.sv
// rtl/tdc_sequencer.sv - runs a burst of 2^k TDC measurements and sends the mean and max position
module tdc_sequencer #(
  parameter int SETTLE_CYCLES = 4,
  parameter int STAGES        = 10,
  parameter int POS_W         = 4
) (
  input  logic           clk,
  input  logic           rst,
  tdc_sequencer_if.slave bus
);
  localparam int SUM_W = POS_W + 7;
  localparam logic [POS_W-1:0] STAGES_C = POS_W'(STAGES);

  typedef enum logic [3:0] {
    S_IDLE, S_LAUNCH, S_SETTLE, S_ACCUM,
    S_SEND_AVG, S_WAIT_HI_A, S_WAIT_LO_A,
    S_SEND_MAX, S_WAIT_HI_M, S_WAIT_LO_M
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       k_q, k_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [7:0]       count_q, count_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [POS_W-1:0] max_q, max_d;
  logic             tdc_launch_q, tdc_launch_d;
  logic             tx_start_q, tx_start_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             busy_q, busy_d;
  logic             cmd_drop_q, cmd_drop_d;

  logic             accept;
  logic [POS_W-1:0] pos_clamped;
  logic             unused_cmd_bit;

  assign unused_cmd_bit = bus.cmd_data[3];
  assign accept      = bus.cmd_valid && (bus.cmd_data[7:4] == 4'hA) && (state_q == S_IDLE);
  assign pos_clamped = (bus.pos_i > STAGES_C) ? STAGES_C : bus.pos_i;

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    cnt_d     = cnt_q;
    count_d   = count_q;
    sum_d     = sum_q;
    max_d     = max_q;
    tx_start_d = 1'b0;
    tx_data_d = tx_data_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          k_d     = bus.cmd_data[2:0];
          sum_d   = '0;
          max_d   = '0;
          count_d = '0;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        cnt_d   = 8'(SETTLE_CYCLES);
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) state_d = S_ACCUM;
      end
      S_ACCUM: begin
        sum_d   = sum_q + SUM_W'(pos_clamped);
        if (pos_clamped > max_q) max_d = pos_clamped;
        count_d = count_q + 8'd1;
        if (({1'b0, count_q} + 9'd1) == (9'd1 << k_q)) state_d = S_SEND_AVG;
        else                                            state_d = S_LAUNCH;
      end
      S_SEND_AVG: begin
        if (!bus.tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = 8'(sum_q >> k_q);
          state_d    = S_WAIT_HI_A;
        end
      end
      S_WAIT_HI_A: if (bus.tx_busy)  state_d = S_WAIT_LO_A;
      S_WAIT_LO_A: if (!bus.tx_busy) state_d = S_SEND_MAX;
      S_SEND_MAX: begin
        if (!bus.tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = 8'(max_q);
          state_d    = S_WAIT_HI_M;
        end
      end
      S_WAIT_HI_M: if (bus.tx_busy)  state_d = S_WAIT_LO_M;
      S_WAIT_LO_M: if (!bus.tx_busy) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with the state they describe.
    tdc_launch_d = (state_d == S_LAUNCH);
    busy_d       = (state_d != S_IDLE);
    cmd_drop_d   = bus.cmd_valid && !accept;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      k_q          <= '0;
      cnt_q        <= '0;
      count_q      <= '0;
      sum_q        <= '0;
      max_q        <= '0;
      tdc_launch_q <= 1'b0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= '0;
      busy_q       <= 1'b0;
      cmd_drop_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      cnt_q        <= cnt_d;
      count_q      <= count_d;
      sum_q        <= sum_d;
      max_q        <= max_d;
      tdc_launch_q <= tdc_launch_d;
      tx_start_q   <= tx_start_d;
      tx_data_q    <= tx_data_d;
      busy_q       <= busy_d;
      cmd_drop_q   <= cmd_drop_d;
    end
  end

  assign bus.tdc_launch = tdc_launch_q;
  assign bus.tx_start   = tx_start_q;
  assign bus.tx_data    = tx_data_q;
  assign bus.busy       = busy_q;
  assign bus.cmd_drop   = cmd_drop_q;
endmodule

// File: tb/tb_tdc_sequencer.sv
// tb/tb_tdc_sequencer.sv - directed self-checking bench for tdc_sequencer
module tb_tdc_sequencer;
  logic clk;
  logic rst;
  logic [3:0] pos_man;
  logic [3:0] pos_auto_v;
  logic       pos_auto;
  logic       model_busy;
  logic       bp_busy;

  tdc_sequencer_if #(.POS_W(4)) bus();

  assign bus.pos_i   = pos_auto ? pos_auto_v : pos_man;
  assign bus.tx_busy = model_busy | bp_busy;

  tdc_sequencer #(.SETTLE_CYCLES(4), .STAGES(10), .POS_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         n_checks = 0;
  int         n_err    = 0;
  int         cyc      = 0;
  int         acc_cyc  = 0;
  int         n_drop   = 0;
  int         viol     = 0;
  int         pos_base = 0;
  int         launch_t[$];
  logic [7:0] tx_log[$];
  logic [3:0] pos_tbl[4];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Launch/drop monitor; also feeds the per-sample position table to pos_i.
  initial begin
    pos_auto_v = '0;
    forever begin
      @(negedge clk);
      if (bus.tdc_launch === 1'b1) begin
        launch_t.push_back(cyc);
        pos_auto_v = pos_tbl[(launch_t.size() - 1 - pos_base) & 3];
      end
      if (bus.cmd_drop === 1'b1) n_drop++;
      if (bus.tx_start === 1'b1 && bus.tx_busy === 1'b1) viol++;
    end
  end

  // UART transmitter model: busy for 10 cycles starting the cycle after a start request.
  initial begin
    model_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.tx_start === 1'b1) begin
        tx_log.push_back(bus.tx_data);
        @(posedge clk);
        #1 model_busy = 1'b1;
        repeat (10) @(posedge clk);
        #1 model_busy = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, "_launch"},   32'(bus.tdc_launch), 0);
    chk({tag, "_tx_start"}, 32'(bus.tx_start),   0);
    chk({tag, "_tx_data"},  32'(bus.tx_data),    0);
    chk({tag, "_busy"},     32'(bus.busy),       0);
    chk({tag, "_drop"},     32'(bus.cmd_drop),   0);
  endtask

  task automatic send_cmd(input logic [7:0] b);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = b;
    acc_cyc       = cyc;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int bound, input string tag);
    int n;
    n = 0;
    while (bus.busy !== 1'b0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(n < bound), 1);
  endtask

  task automatic chk_bytes(input string tag, input int base, input logic [7:0] b0, input logic [7:0] b1);
    chk({tag, "_ntx"}, tx_log.size() - base, 2);
    chk({tag, "_avg"}, 32'(tx_log[base]), 32'(b0));
    chk({tag, "_max"}, 32'(tx_log[base + 1]), 32'(b1));
  endtask

  initial begin
    int lb;
    int tb;
    int nd;
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = '0;
    pos_auto      = 1'b0;
    pos_man       = '0;
    bp_busy       = 1'b0;
    pos_tbl       = '{4'd0, 4'd0, 4'd0, 4'd0};
    repeat (3) @(negedge clk);
    chk_outs_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Single sample: pos_i is 7 only in the sampling cycle, clamped 15 elsewhere.
    pos_man = 4'd15;
    lb = launch_t.size();
    tb = tx_log.size();
    send_cmd(8'hA0);
    chk("t1_launch_c1", 32'(bus.tdc_launch), 1);
    chk("t1_busy_c1",   32'(bus.busy), 1);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1 pos_man = 4'd7;
    @(posedge clk);
    #1 pos_man = 4'd15;
    wait_idle(200, "t1_idle");
    chk("t1_nlaunch", launch_t.size() - lb, 1);
    chk("t1_launch_cycle", launch_t[lb] - acc_cyc, 1);
    chk_bytes("t1", tb, 8'h07, 8'h07);
    chk("t1_busy_after", 32'(bus.busy), 0);

    // Four-sample average.
    pos_tbl  = '{4'd3, 4'd5, 4'd6, 4'd10};
    pos_base = launch_t.size();
    pos_auto = 1'b1;
    lb = launch_t.size();
    tb = tx_log.size();
    send_cmd(8'hA2);
    wait_idle(400, "t2_idle");
    chk("t2_nlaunch", launch_t.size() - lb, 4);
    for (int i = 1; i < 4; i++)
      chk("t2_spacing", launch_t[lb + i] - launch_t[lb + i - 1], 6);
    chk_bytes("t2", tb, 8'h06, 8'h0A);

    // Full 128-sample burst with clamped positions.
    pos_tbl  = '{4'd15, 4'd15, 4'd15, 4'd15};
    pos_base = launch_t.size();
    lb = launch_t.size();
    tb = tx_log.size();
    send_cmd(8'hA7);
    wait_idle(1500, "t3_idle");
    chk("t3_nlaunch", launch_t.size() - lb, 128);
    chk_bytes("t3", tb, 8'h0A, 8'h0A);

    // Bad opcode in IDLE.
    lb = launch_t.size();
    tb = tx_log.size();
    nd = n_drop;
    send_cmd(8'h55);
    chk("t4_drop_pulse", 32'(bus.cmd_drop), 1);
    chk("t4_busy", 32'(bus.busy), 0);
    repeat (10) @(negedge clk);
    chk("t4_ndrop", n_drop - nd, 1);
    chk("t4_nlaunch", launch_t.size() - lb, 0);
    chk("t4_ntx", tx_log.size() - tb, 0);

    // Valid command while a burst is running.
    pos_tbl  = '{4'd4, 4'd8, 4'd4, 4'd8};
    pos_base = launch_t.size();
    lb = launch_t.size();
    tb = tx_log.size();
    send_cmd(8'hA1);
    repeat (3) @(negedge clk);
    nd = n_drop;
    send_cmd(8'hA1);
    chk("t5_drop_pulse", 32'(bus.cmd_drop), 1);
    wait_idle(400, "t5_idle");
    chk("t5_ndrop", n_drop - nd, 1);
    chk("t5_nlaunch", launch_t.size() - lb, 2);
    chk_bytes("t5", tb, 8'h06, 8'h08);

    // Transmitter back-pressure across the SEND_AVG entry.
    pos_tbl  = '{4'd9, 4'd9, 4'd9, 4'd9};
    pos_base = launch_t.size();
    tb = tx_log.size();
    send_cmd(8'hA0);
    bp_busy = 1'b1;
    repeat (50) @(negedge clk);
    chk("t6_no_tx_held", tx_log.size() - tb, 0);
    chk("t6_start_low", 32'(bus.tx_start), 0);
    bp_busy = 1'b0;
    @(negedge clk);
    chk("t6_start_after_fall", 32'(bus.tx_start), 1);
    wait_idle(400, "t6_idle");
    chk_bytes("t6", tb, 8'h09, 8'h09);

    // Asynchronous reset in SETTLE, then a fresh burst.
    pos_tbl  = '{4'd2, 4'd2, 4'd2, 4'd2};
    send_cmd(8'hA0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_outs_zero("t7_rst");
    lb = launch_t.size();
    tb = tx_log.size();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("t7_nlaunch_after", launch_t.size() - lb, 0);
    chk("t7_ntx_after", tx_log.size() - tb, 0);
    chk("t7_busy_after", 32'(bus.busy), 0);
    pos_base = launch_t.size();
    tb = tx_log.size();
    send_cmd(8'hA0);
    wait_idle(200, "t7_idle");
    chk_bytes("t7", tb, 8'h02, 8'h02);

    chk("start_while_tx_busy", viol, 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/tdc_sequencer.md
# tdc_sequencer

Measurement controller sitting between the UART receiver, the TDC delay line and the UART transmitter. A host command byte starts a burst of 2^k TDC measurements. For each measurement the block pulses the TDC launch, waits for the delay line to settle, and samples the priority-encoded stage position. It then returns two bytes over the UART transmitter: the truncated mean position, then the maximum position.

## Interface
Parameters:
- SETTLE_CYCLES, 4: cycles between the launch pulse and sampling `pos_i`; legal range 1..255.
- STAGES, 10: number of delay stages; `pos_i` is clamped to this value.
- POS_W, 4: width of the encoded position input.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state and outputs.
- cmd_valid  in  1  one-cycle strobe: a received byte is on `cmd_data`.
- cmd_data  in  8  command byte; [7:4] is the opcode, [2:0] is k, [3] is ignored.
- pos_i  in  POS_W  encoded thermometer position from the priority encoder.
- tdc_launch  out  1  one-cycle pulse that starts one TDC measurement.
- tx_start  out  1  one-cycle request to the UART transmitter.
- tx_data  out  8  byte to transmit; valid while `tx_start` is high.
- tx_busy  in  1  transmitter is serialising a byte.
- busy  out  1  high in every state except IDLE.
- cmd_drop  out  1  one-cycle pulse when a command is rejected.

## Operation
- All outputs are registered. Every output resets to 0; the state resets to IDLE and all counters, sum and max reset to 0.
- A command is accepted only when `cmd_valid`=1, `cmd_data[7:4]`=4'hA and state=IDLE.
  - On accept, latch k, clear sum/max/sample count, go to LAUNCH.
- A command is rejected when `cmd_valid`=1 and either the opcode is not 4'hA or the state is not IDLE.
  - `cmd_drop` pulses on the next cycle.
  - No other effect; an in-flight burst is not disturbed.
- States:
  - IDLE
  - LAUNCH: `tdc_launch`=1 for this cycle; settle counter loaded with SETTLE_CYCLES.
  - SETTLE: decrement counter; when it reaches 0, go to ACCUM.
  - ACCUM: clamp p = min(pos_i, STAGES); sum += p; max = max(max, p); count++.
    - If count+1 == 2^k, go to SEND_AVG; otherwise go to LAUNCH.
  - SEND_AVG: wait until `tx_busy`=0, then pulse `tx_start` with `tx_data` = (sum >> k)[7:0]; go to WAIT_HI_A.
  - WAIT_HI_A: wait until `tx_busy`=1, then go to WAIT_LO_A.
  - WAIT_LO_A: wait until `tx_busy`=0, then go to SEND_MAX.
  - SEND_MAX: same handshake as SEND_AVG, with `tx_data` = {0, max}.
    - Passes through WAIT_HI_M and WAIT_LO_M, then returns to IDLE.
- Arithmetic:
  - sum is POS_W+7 bits (11 bits at default) and is unsigned.
  - The worst case is 128 × 15 = 1920, so sum cannot overflow.
  - The mean is truncated, not rounded.
- `pos_i` is sampled only in ACCUM; its value in any other state is ignored.
- `tx_data` holds its last value when `tx_start` is low.

## Timing
- Command accepted at cycle 0: `busy`=1 and `tdc_launch`=1 at cycle 1.
- `pos_i` is sampled at cycle 2+SETTLE_CYCLES.
- Each sample period is SETTLE_CYCLES+2 cycles. With default parameters, N samples take 6N cycles from the first launch to the first SEND_AVG cycle.
- `tx_start` rises in the first SEND cycle in which `tx_busy`=0. It is never high while `tx_busy`=1.
- The transmitter must raise `tx_busy` within a bounded time after `tx_start`.
  - The block waits in WAIT_HI indefinitely, by design.
- `busy` falls on the cycle after `tx_busy` falls for the second byte. A new command is accepted in the cycle `busy`=0 is first seen.
- Asynchronous reset at any point, including mid-burst or mid-handshake:
  - Outputs go to 0 immediately.
  - No partial byte is requested after reset release.
  - The first valid command after release starts a fresh burst.

## Test plan
- Single sample: cmd 0xA0, `pos_i`=7 constant, `tx_busy` modelled 10 cycles after each start.
  - Expect exactly one `tdc_launch` at cycle 1, `pos_i` sampled at cycle 6.
  - Expect tx bytes 0x07 then 0x07, and `busy` low afterwards.
- Four-sample average: cmd 0xA2, `pos_i` per ACCUM = 3, 5, 6, 10.
  - Expect 4 launch pulses spaced 6 cycles apart.
  - Expect tx bytes 0x06 (24>>2) then 0x0A.
- Clamp and full burst: cmd 0xA7, `pos_i`=15 constant.
  - Expect 128 launches and tx bytes 0x0A, 0x0A.
- Reject: cmd 0x55 in IDLE.
  - Expect a `cmd_drop` pulse and no launch.
- Reject while busy: cmd 0xA1 during a burst.
  - Expect a `cmd_drop` pulse, an unchanged burst and exactly two tx bytes.
- Back-pressure: hold `tx_busy`=1 for 50 cycles entering SEND_AVG.
  - Expect `tx_start` to stay 0, then pulse once the cycle after `tx_busy` falls.
- Reset mid-SETTLE: assert reset for 3 cycles.
  - Expect all outputs 0 immediately, no tx afterwards.
  - Then cmd 0xA0 with `pos_i`=2 must produce 0x02, 0x02.
